// File: rtl/shift_accumulate_multiplier.sv
// -----------------------------------------------------------------------------
// shift_accumulate_multiplier
//
// Sequential unsigned multiplier using add-and-shift, one multiplier bit per
// clock. Releasing reset starts one multiplication. The first edge captures
// the operands, the next WIDTH edges accumulate, and the product is then
// held on a registered output until the next reset.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; releasing it starts a new product
//   M      multiplicand, unsigned, WIDTH bits (sampled only in LOAD)
//   Q      multiplier, unsigned, WIDTH bits (sampled only in LOAD)
//   out    registered product, 2*WIDTH bits; zero until the product is ready
// -----------------------------------------------------------------------------
module shift_accumulate_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  output logic [2*WIDTH-1:0] out
);

  // A one-bit counter is kept for WIDTH=1 so the declaration stays legal.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mq_q,    mq_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [2*WIDTH-1:0] out_q,   out_d;

  // Partial product for the current iteration and the running sum that
  // includes it. The sum is also what lands in out on the last iteration,
  // so the final bit is not lost to a one-cycle-late acc.
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum;

  always_comb begin
    addend = mq_q[0] ? mcand_q : '0;
    sum    = acc_q + addend;

    // NOTE: every next-state signal gets a hold default before the case so
    // that no path leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    case (state_q)
      S_LOAD: begin
        mcand_d = {{WIDTH{1'b0}}, M};
        mq_d    = Q;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mq_d    = mq_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Exactly WIDTH iterations, even when the multiplier is zero.
        if (cnt_q == CNT_LAST) begin
          out_d   = sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Everything holds; operand inputs are ignored until reset.
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      mcand_q <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_shift_accumulate_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_accumulate_multiplier
//
// Directed bench for shift_accumulate_multiplier (WIDTH=32). A reference
// model counts rising edges since reset release, captures M*Q on the first
// one, and predicts out = 0 before edge WIDTH+1 and the product from then on.
// A compare process checks out against that on every falling edge; literal
// expectations for each vector pin the model itself.
// -----------------------------------------------------------------------------
module tb_shift_accumulate_multiplier;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [WIDTH-1:0]  M = '0;
  logic [WIDTH-1:0]  Q = '0;
  logic [2*WIDTH-1:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  shift_accumulate_multiplier #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .M    (M),
    .Q    (Q),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*WIDTH-1:0] act,
                       input logic [2*WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: edges since release and the product of the operands
  // present on the first of those edges.
  // ---------------------------------------------------------------------------
  int                 edges_since_release = 0;
  logic [2*WIDTH-1:0] model_prod = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edges_since_release <= 0;
      model_prod          <= '0;
    end else begin
      if (edges_since_release == 0)
        model_prod <= {{WIDTH{1'b0}}, M} * {{WIDTH{1'b0}}, Q};
      if (edges_since_release < 1000)
        edges_since_release <= edges_since_release + 1;
    end
  end

  function automatic logic [2*WIDTH-1:0] model_out();
    return (edges_since_release >= WIDTH + 1) ? model_prod : '0;
  endfunction

  always @(negedge clk) begin
    check("model_cycle", out, model_out());
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Pulse reset, release with the given operands, check out is still zero
  // after edge WIDTH and equals the literal product after edge WIDTH+1.
  // When wiggle is set the inputs are changed mid-run, which must not matter.
  task automatic run_op(input string name, input logic [WIDTH-1:0] m,
                        input logic [WIDTH-1:0] q,
                        input logic [2*WIDTH-1:0] lit, input bit wiggle);
    @(negedge clk);
    reset = 1'b1;
    M = m;
    Q = q;
    #1;
    check({name, "_in_reset"}, out, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      @(negedge clk);
      if (wiggle && i == 5) begin
        M = ~m;
        Q = ~q;
      end
    end
    check({name, "_edge32"}, out, '0);
    @(negedge clk);
    check({name, "_edge33"}, out, lit);
  endtask

  initial begin
    // 1: reset held two cycles, then all-ones operands; watch 40 cycles.
    reset = 1'b1;
    M = 32'hFFFF_FFFF;
    Q = 32'hFFFF_FFFF;
    @(negedge clk);
    check("reset_state", out, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (WIDTH) @(negedge clk);
    check("max_edge32", out, '0);
    @(negedge clk);
    check("max_edge33", out, 64'hFFFF_FFFE_0000_0001);
    repeat (7) @(negedge clk);
    check("max_stable", out, 64'hFFFF_FFFE_0000_0001);

    // 2, 3, 4: small and zero operands.
    run_op("f_x_f",    32'h0000_000F, 32'h0000_000F, 64'd225, 1'b0);
    run_op("16_x_4",   32'h0000_0010, 32'h0000_0004, 64'd64,  1'b0);
    run_op("m_x_zero", 32'h1234_5678, 32'h0000_0000, 64'd0,   1'b0);
    run_op("zero_x_q", 32'h0000_0000, 32'hFFFF_FFFF, 64'd0,   1'b0);
    // Inputs toggled during RUN must not disturb the captured operands.
    run_op("wiggle",   32'h0001_0003, 32'h8000_0001, 64'h0000_8001_8001_0003, 1'b1);

    // 5: abort a max-operand run between edges 10 and 11.
    @(negedge clk);
    reset = 1'b1;
    M = 32'hFFFF_FFFF;
    Q = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_async", out, '0);
    M = 32'd3;
    Q = 32'd5;
    @(negedge clk);
    reset = 1'b0;
    repeat (WIDTH + 1) @(negedge clk);
    check("after_abort", out, 64'd15);

    // 6: 7x9 completes, then the inputs move without a reset.
    run_op("7_x_9", 32'd7, 32'd9, 64'd63, 1'b0);
    M = 32'd2;
    Q = 32'd2;
    repeat (40) @(negedge clk);
    check("done_hold", out, 64'd63);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
